// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the Wishbone UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;

    function automatic logic [31:0] status_word(input logic busy, input logic full,
                                                input logic empty);
        logic [31:0] w;
        w             = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full is honoured only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone pipelined slave wrapping an 8N1 UART transmitter with a byte FIFO,
// status register and programmable baud divider.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic [15:0]   baud_div;
    logic [15:0]   baud_shadow;
    logic [15:0]   baud_cnt;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx;
    logic [1:0]    reg_sel;
    logic [31:0]   rdata;
    logic          accept;
    logic          push;
    logic          pop;
    logic          busy;
    logic          bit_done;
    logic          frame_end;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign reg_sel    = wb_adr_i[3:2];
    assign wb_stall_o = wb_cyc_i & wb_stb_i & wb_we_i & (reg_sel == REG_TXDATA)
                        & wb_sel_i[0] & fifo_full;
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign push       = accept & wb_we_i & (reg_sel == REG_TXDATA) & wb_sel_i[0];
    assign busy       = (state != ST_IDLE);
    assign bit_done   = (baud_cnt == 16'd0);
    assign frame_end  = (state == ST_STOP) & bit_done;
    // A queued byte is taken either from idle or straight out of STOP, so frames abut.
    assign pop        = ~fifo_empty & ((state == ST_IDLE) | frame_end);
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:2],
                           wb_dat_i[31:16], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (wb_dat_i[7:0]),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_STATUS: rdata = status_word(busy, fifo_full, fifo_empty);
            REG_BAUD:   rdata = {16'h0, baud_div};
            default:    rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
            baud_div <= DIV_RESET;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept & ~wb_we_i) ? rdata : 32'h0;
            if (accept && wb_we_i && reg_sel == REG_BAUD) begin
                if (wb_sel_i[0]) baud_div[7:0]  <= wb_dat_i[7:0];
                if (wb_sel_i[1]) baud_div[15:8] <= wb_dat_i[15:8];
            end
        end
    end

    // tx_o is registered alongside the state so the line never glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            baud_shadow <= DIV_RESET;
            baud_cnt    <= 16'd0;
            shift_q     <= 8'h0;
            bit_idx     <= 3'd0;
            tx_o        <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state       <= ST_START;
                        shift_q     <= fifo_rdata;
                        baud_shadow <= baud_div;
                        baud_cnt    <= baud_div;
                        tx_o        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state    <= ST_DATA;
                        baud_cnt <= baud_shadow;
                        bit_idx  <= 3'd0;
                        tx_o     <= shift_q[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= baud_shadow;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state       <= ST_START;
                            shift_q     <= fifo_rdata;
                            baud_shadow <= baud_div;
                            baud_cnt    <= baud_div;
                            tx_o        <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b1;
        end else begin
            irq_o <= fifo_empty & ~busy;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Testbench for wb_uart_tx: drives Wishbone traffic and decodes the logged serial line
// against ideal 8N1 frame waveforms.
module tb_wb_uart_tx;

    localparam int LOGN = 8192;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        tx_o;
    logic        irq_o;

    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          b2b_start = -1;
    logic        line_log [LOGN];
    logic [7:0]  exp_q [$];

    wb_uart_tx #(
        .FIFO_DEPTH (16),
        .DIV_RESET  (16'd867)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .tx_o       (tx_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // line_log[n] holds the serial level during the clock period after posedge n.
    always @(negedge clk_i) begin
        if (cyc_cnt < LOGN) line_log[cyc_cnt] <= tx_o;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0;
        wb_sel_i = 4'h0;
        wb_dat_i = 32'h0;
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output int waited,
                             output int acc_cyc, output logic ack_seen);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {28'h0, adr};
        wb_sel_i = sel;
        wb_dat_i = dat;
        waited   = 0;
        acc_cyc  = -1;
        ack_seen = 1'b0;
        #1;
        while (wb_stall_o === 1'b1 && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (wb_stall_o !== 1'b0) begin
            total++;
            bad++;
            $display("[TB] FAIL write_stall_timeout: stall=%b after %0d cycles, required 0", wb_stall_o, waited);
            bus_idle();
        end else begin
            @(negedge clk_i);
            acc_cyc  = cyc_cnt;
            ack_seen = wb_ack_o;
            if (adr == 4'h0 && sel[0]) exp_q.push_back(dat[7:0]);
        end
    endtask

    task automatic bus_read(input logic [3:0] adr, output logic [31:0] data,
                            output logic [2:0] ackpat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = {28'h0, adr};
        wb_sel_i = 4'hF;
        wb_dat_i = 32'h0;
        #1;
        ackpat[2] = wb_ack_o;
        @(negedge clk_i);
        ackpat[1] = wb_ack_o;
        data      = wb_dat_o;
        bus_idle();
        @(negedge clk_i);
        ackpat[0] = wb_ack_o;
    endtask

    function automatic int find_low(input int from);
        if (from < 0) return -1;
        for (int n = from; n < cyc_cnt && n < LOGN; n++) begin
            if (line_log[n] === 1'b0) return n;
        end
        return -1;
    endfunction

    // Ideal frame: start bit, eight data bits LSB first, stop bit, each p clocks long.
    function automatic int frame_errs(input int start, input int p, input logic [7:0] b);
        int errs = 0;
        if (start < 0) return 10 * p;
        for (int k = 0; k < 10 * p; k++) begin
            int   bitn;
            logic e;
            bitn = k / p;
            if (bitn == 0)      e = 1'b0;
            else if (bitn == 9) e = 1'b1;
            else                e = b[bitn-1];
            if (start + k >= LOGN || start + k >= cyc_cnt || line_log[start+k] !== e) errs++;
        end
        return errs;
    endfunction

    function automatic int high_errs(input int from, input int to);
        int errs = 0;
        if (from < 0) return 1;
        for (int n = from; n <= to && n < LOGN; n++) begin
            if (line_log[n] !== 1'b1) errs++;
        end
        return errs;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        logic [2:0]  ap;
        $display("[TB] test_reset");
        bus_idle();
        #3 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        total++; if (tx_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_o); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_irq: got %b expected 1", irq_o); end
        total++; if (wb_ack_o !== 1'b0 || wb_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack_stall: got ack=%b stall=%b expected 0/0", wb_ack_o, wb_stall_o); end
        total++; if (wb_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_dat: got %h expected 0", wb_dat_o); end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        bus_read(4'h4, d, ap);
        total++; if (ap !== 3'b010) begin bad++; $display("[TB] FAIL status_ack_timing: got %b expected 010", ap); end
        total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL reset_status: got %h expected 00000001", d); end
        total++; if (tx_o !== 1'b1 || irq_o !== 1'b1) begin bad++; $display("[TB] FAIL idle_lines: got tx=%b irq=%b expected 1/1", tx_o, irq_o); end
        bus_read(4'h8, d, ap);
        total++; if (d !== 32'd867) begin bad++; $display("[TB] FAIL reset_baud: got %0d expected 867", d); end
        bus_read(4'h0, d, ap);
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL txdata_read: got %h expected 0", d); end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        logic [2:0]  ap;
        int          w, acc, s, rise, guard;
        logic        ack;
        $display("[TB] test_single_byte");
        exp_q.delete();
        bus_write(4'h8, 4'b0011, 32'h0000_0003, w, acc, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("[TB] FAIL write_ack: got %b expected 1", ack); end
        bus_read(4'h8, d, ap);
        total++; if (d !== 32'd3) begin bad++; $display("[TB] FAIL baud_readback: got %0d expected 3", d); end
        bus_write(4'h0, 4'b0001, 32'h0000_00A5, w, acc, ack);
        bus_idle();
        repeat (5) @(negedge clk_i);
        s = find_low(acc);
        total++; if (s != acc + 1) begin bad++; $display("[TB] FAIL start_latency: got start=%0d expected %0d", s, acc + 1); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_during_frame: got %b expected 0", irq_o); end
        guard = 0;
        while (irq_o !== 1'b1 && guard < 200) begin @(negedge clk_i); guard++; end
        rise = cyc_cnt;
        total++; if (irq_o !== 1'b1 || rise != s + 41) begin bad++; $display("[TB] FAIL irq_return: got irq=%b at %0d expected 1 at %0d", irq_o, rise, s + 41); end
        total++; if (frame_errs(s, 4, 8'hA5) != 0) begin bad++; $display("[TB] FAIL frame_A5: got %0d bad samples expected 0", frame_errs(s, 4, 8'hA5)); end
    endtask

    task automatic test_fifo_full();
        int   w, acc, ack_dummy_first, stall_early, w18, acc18;
        logic ack;
        $display("[TB] test_fifo_full");
        exp_q.delete();
        stall_early     = 0;
        ack_dummy_first = -1;
        w18             = 0;
        acc18           = -1;
        for (int i = 0; i < 18; i++) begin
            bus_write(4'h0, 4'b0001, $urandom & 32'hFF, w, acc, ack);
            if (i == 0) ack_dummy_first = acc;
            if (i < 17 && w != 0) stall_early++;
            if (i == 17) begin w18 = w; acc18 = acc; end
        end
        bus_idle();
        b2b_start = find_low(ack_dummy_first);
        total++; if (stall_early != 0) begin bad++; $display("[TB] FAIL early_stall: got %0d stalled writes expected 0", stall_early); end
        total++; if (w18 == 0) begin bad++; $display("[TB] FAIL write18_stall: got %0d stall cycles expected >0", w18); end
        total++; if (acc18 != b2b_start + 41) begin bad++; $display("[TB] FAIL write18_accept: got cycle %0d expected %0d", acc18, b2b_start + 41); end
    endtask

    task automatic test_push_pop();
        int          w, acc;
        logic        ack;
        logic [31:0] d;
        logic [2:0]  ap;
        $display("[TB] test_push_pop");
        bus_write(4'h0, 4'b0001, $urandom & 32'hFF, w, acc, ack);
        bus_idle();
        total++; if (w == 0 || acc != b2b_start + 81) begin bad++; $display("[TB] FAIL push_after_pop: got stall=%0d accept=%0d expected >0 and %0d", w, acc, b2b_start + 81); end
        bus_read(4'h4, d, ap);
        total++; if (d !== 32'h6) begin bad++; $display("[TB] FAIL status_full: got %h expected 00000006", d); end
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h0;
        wb_sel_i = 4'b0001;
        wb_dat_i = 32'h3C;
        #1;
        total++; if (wb_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_when_full: got %b expected 1", wb_stall_o); end
        repeat (3) @(negedge clk_i);
        bus_idle();
    endtask

    task automatic test_back_to_back();
        int frames, errs;
        $display("[TB] test_back_to_back");
        frames = exp_q.size();
        total++; if (frames != 19) begin bad++; $display("[TB] FAIL queued_count: got %0d expected 19", frames); end
        while (cyc_cnt < b2b_start + 820) @(negedge clk_i);
        for (int i = 0; i < frames; i++) begin
            errs = frame_errs(b2b_start + 40 * i, 4, exp_q[i]);
            total++; if (errs != 0) begin bad++; $display("[TB] FAIL b2b_frame%0d: got %0d bad samples for byte %h expected 0", i, errs, exp_q[i]); end
        end
        errs = high_errs(b2b_start + 760, cyc_cnt - 1);
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL abandoned_write: got %0d low samples after last frame expected 0", errs); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_irq: got %b expected 1", irq_o); end
    endtask

    task automatic test_divisor_change();
        int         w, acc1, acc, s, errs;
        logic       ack;
        logic [7:0] b1, b2;
        $display("[TB] test_divisor_change");
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(4'h0, 4'b0001, {24'h0, b1}, w, acc1, ack);
        bus_write(4'h0, 4'b0001, {24'h0, b2}, w, acc, ack);
        bus_write(4'h8, 4'b0011, 32'h0000_0007, w, acc, ack);
        bus_idle();
        repeat (2) @(negedge clk_i);
        s = find_low(acc1);
        while (cyc_cnt < s + 140) @(negedge clk_i);
        errs = frame_errs(s, 4, b1);
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL div_frame1: got %0d bad samples expected 0", errs); end
        errs = frame_errs(s + 40, 8, b2);
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL div_frame2: got %0d bad samples expected 0", errs); end
        errs = high_errs(s + 120, cyc_cnt - 1);
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL div_idle_after: got %0d low samples expected 0", errs); end
    endtask

    task automatic test_reset_mid_frame();
        int          w, acc1, acc, s, rel, errs;
        logic        ack;
        logic [31:0] d;
        logic [2:0]  ap;
        $display("[TB] test_reset_mid_frame");
        bus_write(4'h0, 4'b0001, $urandom & 32'hF7, w, acc1, ack);
        bus_write(4'h0, 4'b0001, $urandom & 32'hFF, w, acc, ack);
        bus_write(4'h0, 4'b0001, $urandom & 32'hFF, w, acc, ack);
        bus_idle();
        repeat (2) @(negedge clk_i);
        s = find_low(acc1);
        while (cyc_cnt < s + 35) @(negedge clk_i);
        total++; if (tx_o !== 1'b0) begin bad++; $display("[TB] FAIL data_bit3: got %b expected 0", tx_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (tx_o !== 1'b1 || irq_o !== 1'b1) begin bad++; $display("[TB] FAIL async_reset: got tx=%b irq=%b expected 1/1", tx_o, irq_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        rel = cyc_cnt;
        @(negedge clk_i);
        bus_read(4'h4, d, ap);
        total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL post_reset_status: got %h expected 00000001", d); end
        bus_read(4'h8, d, ap);
        total++; if (d !== 32'd867) begin bad++; $display("[TB] FAIL post_reset_baud: got %0d expected 867", d); end
        repeat (100) @(negedge clk_i);
        errs = high_errs(rel, cyc_cnt - 1);
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL residual_tx: got %0d low samples expected 0", errs); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fifo_full();
        test_push_pop();
        test_back_to_back();
        test_divisor_change();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
